// File: rtl/assert_no_underflow_logic.sv
// ---------------------------------------------------------------------------
// assert_no_underflow_logic
//   Synthesizable no_underflow checker. Once test_expr has been sampled at
//   min, the next sample must either stay at min or land strictly inside
//   (min, max). Dropping below min, or jumping to max or beyond, is flagged.
//   This is the low-end companion of the no_overflow checker.
//
// Parameters
//   width                bit width of test_expr
//   min, max             unsigned range bounds, truncated to width bits
//   OVL_COVER_BASIC_ON   enables cov_changes
//   OVL_COVER_CORNER_ON  enables cov_at_min / cov_at_max
//   CNT_WIDTH            width of each saturating coverage counter
//
// Ports
//   clk            sampling clock, rising edge
//   reset_n        asynchronous active-low reset
//   test_expr      monitored value
//   xzcheck_enable 1 = report X/Z bits on test_expr through fire[1]
//   fire[0]        underflow seen on the previous edge (1-cycle pulse)
//   fire[1]        X/Z sample seen on the previous edge (1-cycle pulse)
//   fire[2]        some enabled coverage counter advanced on the previous edge
//   cov_changes    armed clean samples that differ from the previous sample
//   cov_at_min     clean samples equal to min
//   cov_at_max     clean samples equal to max
// ---------------------------------------------------------------------------
module assert_no_underflow_logic #(
   parameter int width               = 8,
   parameter int min                 = 0,
   parameter int max                 = 1,
   parameter int OVL_COVER_BASIC_ON  = 1,
   parameter int OVL_COVER_CORNER_ON = 1,
   parameter int CNT_WIDTH           = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [width-1:0]     test_expr,
   input  logic                 xzcheck_enable,
   output logic [2:0]           fire,
   output logic [CNT_WIDTH-1:0] cov_changes,
   output logic [CNT_WIDTH-1:0] cov_at_min,
   output logic [CNT_WIDTH-1:0] cov_at_max
);

   localparam logic [width-1:0]     MIN_T   = width'(min);
   localparam logic [width-1:0]     MAX_T   = width'(max);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic                 BASIC   = (OVL_COVER_BASIC_ON != 0);
   localparam logic                 CORNER  = (OVL_COVER_CORNER_ON != 0);

   // ARMED means r_prev holds a clean sample that the next edge may be
   // checked against; IDLE means there is no usable history.
   typedef enum logic {IDLE, ARMED} state_t;

   state_t               r_state;
   logic [width-1:0]     r_prev;
   logic [2:0]           r_fire;
   logic [CNT_WIDTH-1:0] r_cov_changes;
   logic [CNT_WIDTH-1:0] r_cov_at_min;
   logic [CNT_WIDTH-1:0] r_cov_at_max;

   logic w_xz;
   logic w_clean;
   logic w_armed;
   logic w_uflow;
   logic w_inc_chg;
   logic w_inc_min;
   logic w_inc_max;

   // The reduction XOR is X whenever any bit is X or Z. Synthesis treats
   // the case-equality as false, so the hardware always sees clean data.
   assign w_xz    = ((^test_expr) === 1'bx);
   assign w_clean = ~w_xz;
   assign w_armed = (r_state == ARMED);

   // Staying at min is legal, and so is moving strictly inside the range.
   // Reaching max directly from min counts as a violation.
   assign w_uflow = w_armed && (r_prev == MIN_T) && w_clean &&
                    (test_expr != MIN_T) &&
                    ((test_expr < MIN_T) || (test_expr >= MAX_T));

   // An increment is suppressed at saturation, so fire[2] marks a real change.
   assign w_inc_chg = BASIC && w_armed && w_clean &&
                      (test_expr != r_prev) && (r_cov_changes != CNT_MAX);
   assign w_inc_min = CORNER && w_clean && (test_expr == MIN_T) &&
                      (r_cov_at_min != CNT_MAX);
   assign w_inc_max = CORNER && w_clean && (test_expr == MAX_T) &&
                      (r_cov_at_max != CNT_MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_prev        <= '0;
         r_fire        <= '0;
         r_cov_changes <= '0;
         r_cov_at_min  <= '0;
         r_cov_at_max  <= '0;
      end else begin
         r_prev <= test_expr;
         case (r_state)
            IDLE:    if (w_clean) r_state <= ARMED;
            ARMED:   if (w_xz)    r_state <= IDLE;
            default:              r_state <= IDLE;
         endcase
         r_fire <= {(w_inc_chg | w_inc_min | w_inc_max),
                    (xzcheck_enable & w_xz),
                    w_uflow};
         if (w_inc_chg) r_cov_changes <= r_cov_changes + CNT_ONE;
         if (w_inc_min) r_cov_at_min  <= r_cov_at_min  + CNT_ONE;
         if (w_inc_max) r_cov_at_max  <= r_cov_at_max  + CNT_ONE;
      end
   end

   assign fire        = r_fire;
   assign cov_changes = r_cov_changes;
   assign cov_at_min  = r_cov_at_min;
   assign cov_at_max  = r_cov_at_max;

endmodule
